// File: rtl/fl_vadd_feeder.sv
// Splits an interleaved x/y word stream into two operand FIFOs for the vector adder; optional last flag with FL_VADD_FEEDER_TLAST_EN.
// Latency: an accepted word reaches its operand port one cycle later; done follows the final pop by one cycle.
// Backpressure: in_ready drops while the FIFO for the current phase is full; each operand port stalls independently.

module fl_vadd_feeder_fifo #(
   parameter int W     = 32,
   parameter int DEPTH = 4
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         push,
   input  logic [W-1:0] wr_dat,
   input  logic         pop,
   output logic [W-1:0] rd_dat,
   output logic         full,
   output logic         empty
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [W-1:0]  mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [CW-1:0] cnt;
   logic          do_push;
   logic          do_pop;

   assign full    = (cnt == CW'(DEPTH));
   assign empty   = (cnt == '0);
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   // Head is forced to zero when empty so idle outputs never show stale words.
   assign rd_dat  = empty ? '0 : mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         cnt    <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + AW'(1);
         if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
         case ({do_push, do_pop})
            2'b10:   cnt <= cnt + CW'(1);
            2'b01:   cnt <= cnt - CW'(1);
            default: cnt <= cnt;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= wr_dat;
   end
endmodule

module fl_vadd_feeder #(
   parameter int DATA_W     = 32,
   parameter int FIFO_DEPTH = 4,
   parameter int LEN_W      = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [LEN_W-1:0]  cfg_len,
   input  logic              cfg_start,
   output logic              busy,
   output logic              done,
   input  logic [DATA_W-1:0] in_data,
   input  logic              in_valid,
   output logic              in_ready,
   output logic [DATA_W-1:0] out_x_data,
   output logic              out_x_valid,
   input  logic              x_ready,
   output logic              out_x_last,
   output logic [DATA_W-1:0] out_y_data,
   output logic              out_y_valid,
   input  logic              y_ready,
   output logic              out_y_last
);
   typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

   state_t           state, state_nxt;
   logic             phase_y, phase_y_nxt;
   logic [LEN_W-1:0] len_q, len_nxt;
   logic [LEN_W-1:0] pair_cnt, pair_nxt;
   logic             zero_done_q, zero_done_nxt;
   logic             x_push, y_push;
   logic             x_full, x_empty, y_full, y_empty;
   logic             final_pair;

   assign final_pair = (pair_cnt == len_q - LEN_W'(1));
   assign busy       = (state != IDLE);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state       <= IDLE;
         phase_y     <= 1'b0;
         len_q       <= '0;
         pair_cnt    <= '0;
         zero_done_q <= 1'b0;
      end else begin
         state       <= state_nxt;
         phase_y     <= phase_y_nxt;
         len_q       <= len_nxt;
         pair_cnt    <= pair_nxt;
         zero_done_q <= zero_done_nxt;
      end
   end

   always_comb begin
      state_nxt     = state;
      phase_y_nxt   = phase_y;
      len_nxt       = len_q;
      pair_nxt      = pair_cnt;
      zero_done_nxt = 1'b0;
      in_ready      = 1'b0;
      x_push        = 1'b0;
      y_push        = 1'b0;
      done          = zero_done_q;
      case (state)
         IDLE: begin
            if (cfg_start) begin
               if (cfg_len == '0) begin
                  zero_done_nxt = 1'b1;
               end else begin
                  len_nxt     = cfg_len;
                  pair_nxt    = '0;
                  phase_y_nxt = 1'b0;
                  state_nxt   = RUN;
               end
            end
         end
         RUN: begin
            // Full FIFO blocks the push even if it is being popped this cycle.
            in_ready = phase_y ? !y_full : !x_full;
            if (in_valid && in_ready) begin
               if (!phase_y) begin
                  x_push      = 1'b1;
                  phase_y_nxt = 1'b1;
               end else begin
                  y_push      = 1'b1;
                  phase_y_nxt = 1'b0;
                  pair_nxt    = pair_cnt + LEN_W'(1);
                  if (final_pair) state_nxt = DRAIN;
               end
            end
         end
         DRAIN: begin
            if (x_empty && y_empty) begin
               done      = 1'b1;
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

`ifdef FL_VADD_FEEDER_TLAST_EN
   localparam int FW = DATA_W + 1;
   logic [FW-1:0] x_wdat, x_rdat, y_wdat, y_rdat;
   assign x_wdat     = {final_pair, in_data};
   assign y_wdat     = {final_pair, in_data};
   assign out_x_data = x_rdat[DATA_W-1:0];
   assign out_x_last = x_rdat[DATA_W];
   assign out_y_data = y_rdat[DATA_W-1:0];
   assign out_y_last = y_rdat[DATA_W];
`else
   localparam int FW = DATA_W;
   logic [FW-1:0] x_wdat, x_rdat, y_wdat, y_rdat;
   assign x_wdat     = in_data;
   assign y_wdat     = in_data;
   assign out_x_data = x_rdat;
   assign out_x_last = 1'b0;
   assign out_y_data = y_rdat;
   assign out_y_last = 1'b0;
`endif

   assign out_x_valid = !x_empty;
   assign out_y_valid = !y_empty;

   fl_vadd_feeder_fifo #(.W(FW), .DEPTH(FIFO_DEPTH)) u_x_fifo (
      .clk    (clk),
      .rst_n  (rst_n),
      .push   (x_push),
      .wr_dat (x_wdat),
      .pop    (x_ready),
      .rd_dat (x_rdat),
      .full   (x_full),
      .empty  (x_empty)
   );

   fl_vadd_feeder_fifo #(.W(FW), .DEPTH(FIFO_DEPTH)) u_y_fifo (
      .clk    (clk),
      .rst_n  (rst_n),
      .push   (y_push),
      .wr_dat (y_wdat),
      .pop    (y_ready),
      .rd_dat (y_rdat),
      .full   (y_full),
      .empty  (y_empty)
   );
endmodule

// File: tb/tb_fl_vadd_feeder.sv
// Bench for fl_vadd_feeder: table of jobs checked against a de-interleaving scoreboard,
// plus hand sequences for backpressure, zero length, start-while-busy and mid-job reset.

module tb_fl_vadd_feeder;
   localparam int DATA_W     = 32;
   localparam int FIFO_DEPTH = 4;
   localparam int LEN_W      = 16;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic [LEN_W-1:0]  cfg_len = '0;
   logic              cfg_start = 1'b0;
   logic              busy, done;
   logic [DATA_W-1:0] in_data = '0;
   logic              in_valid = 1'b0;
   logic              in_ready;
   logic [DATA_W-1:0] out_x_data, out_y_data;
   logic              out_x_valid, out_y_valid, out_x_last, out_y_last;
   logic              x_ready = 1'b0;
   logic              y_ready = 1'b0;

   fl_vadd_feeder #(.DATA_W(DATA_W), .FIFO_DEPTH(FIFO_DEPTH), .LEN_W(LEN_W)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .cfg_len     (cfg_len),
      .cfg_start   (cfg_start),
      .busy        (busy),
      .done        (done),
      .in_data     (in_data),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .out_x_data  (out_x_data),
      .out_x_valid (out_x_valid),
      .x_ready     (x_ready),
      .out_x_last  (out_x_last),
      .out_y_data  (out_y_data),
      .out_y_valid (out_y_valid),
      .y_ready     (y_ready),
      .out_y_last  (out_y_last)
   );

   typedef struct {
      int len;
      int v_pct;
      int x_pct;
      int y_pct;
      bit flt;
      int budget;
      int exp_done;
   } vec_t;

   vec_t        vecs[5];
   logic [31:0] fl[6];
   int n_chk = 0, n_fail = 0;
   int v_pct = 100, x_pct = 100, y_pct = 100;
   int cyc = 0, acc_cnt = 0, done_cnt = 0, done_cyc = 0, last_x_cyc = 0, last_y_cyc = 0;
   logic [31:0] src[$];
   logic [31:0] exp_w[$];
   logic [32:0] got_x[$];
   logic [32:0] got_y[$];

   initial forever #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Monitor at negedge (handshakes that commit on the next posedge), drive at posedge+1.
   initial begin : drv
      logic acc;
      forever begin
         @(negedge clk);
         cyc++;
         acc = 1'b0;
         if (rst_n) begin
            if (in_valid && in_ready) begin
               acc = 1'b1;
               acc_cnt++;
               if (src.size() > 0) void'(src.pop_front());
            end
            if (out_x_valid && x_ready) begin
               got_x.push_back({out_x_last, out_x_data});
               last_x_cyc = cyc;
            end
            if (out_y_valid && y_ready) begin
               got_y.push_back({out_y_last, out_y_data});
               last_y_cyc = cyc;
            end
            if (done) begin
               done_cnt++;
               done_cyc = cyc;
            end
         end
         @(posedge clk);
         #1;
         if (src.size() == 0) in_valid = 1'b0;
         else if (!(in_valid && !acc)) in_valid = ($urandom_range(99) < v_pct);
         in_data = (src.size() > 0) ? src[0] : '0;
         x_ready = ($urandom_range(99) < x_pct);
         y_ready = ($urandom_range(99) < y_pct);
      end
   end

   task automatic load(input int len, input bit flt, input int tag);
      @(negedge clk);
      #2;
      src.delete();
      exp_w.delete();
      got_x.delete();
      got_y.delete();
      acc_cnt = 0; done_cnt = 0; done_cyc = 0; last_x_cyc = 0; last_y_cyc = 0;
      for (int i = 0; i < 2 * len; i++) begin
         logic [31:0] w;
         w = flt ? fl[i] : (32'h1000_0000 + (tag << 20) + i);
         src.push_back(w);
         exp_w.push_back(w);
      end
   endtask

   task automatic start_job(input int len);
      @(posedge clk);
      #1;
      cfg_len   = LEN_W'(len);
      cfg_start = 1'b1;
      @(negedge clk);
      chk("busy_before_start", 32'(busy), 0);
      @(posedge clk);
      #1;
      cfg_start = 1'b0;
      @(negedge clk);
      chk("busy_after_start", 32'(busy), 32'(len != 0));
      chk("done_after_start", 32'(done), 32'(len == 0));
      if (len == 0) chk("in_ready_zero_len", 32'(in_ready), 0);
   endtask

   task automatic wait_done(input int budget);
      int n;
      n = 0;
      while (done_cnt == 0 && n < budget) begin
         @(posedge clk);
         n++;
      end
      chk("done_seen", 32'(done_cnt > 0), 1);
      repeat (6) @(posedge clk);
      @(negedge clk);
      #1;
   endtask

   task automatic check_job(input int len, input int exp_done);
      int lp;
      chk("x_count", got_x.size(), len);
      chk("y_count", got_y.size(), len);
      for (int i = 0; i < len && i < got_x.size(); i++) begin
`ifdef FL_VADD_FEEDER_TLAST_EN
         lp = (i == len - 1) ? 1 : 0;
`else
         lp = 0;
`endif
         chk($sformatf("x_data[%0d]", i), got_x[i][31:0], exp_w[2*i]);
         chk($sformatf("x_last[%0d]", i), 32'(got_x[i][32]), lp);
      end
      for (int i = 0; i < len && i < got_y.size(); i++) begin
`ifdef FL_VADD_FEEDER_TLAST_EN
         lp = (i == len - 1) ? 1 : 0;
`else
         lp = 0;
`endif
         chk($sformatf("y_data[%0d]", i), got_y[i][31:0], exp_w[2*i+1]);
         chk($sformatf("y_last[%0d]", i), 32'(got_y[i][32]), lp);
      end
      chk("done_count", done_cnt, exp_done);
      chk("done_timing", done_cyc, ((last_x_cyc > last_y_cyc) ? last_x_cyc : last_y_cyc) + 1);
      chk("busy_after_done", 32'(busy), 0);
      chk("in_ready_after_done", 32'(in_ready), 0);
   endtask

   task automatic check_reset(input string tag);
      chk({tag, "_in_ready"}, 32'(in_ready), 0);
      chk({tag, "_busy"}, 32'(busy), 0);
      chk({tag, "_done"}, 32'(done), 0);
      chk({tag, "_x_valid"}, 32'(out_x_valid), 0);
      chk({tag, "_y_valid"}, 32'(out_y_valid), 0);
      chk({tag, "_x_last"}, 32'(out_x_last), 0);
      chk({tag, "_y_last"}, 32'(out_y_last), 0);
      chk({tag, "_x_data"}, out_x_data, 0);
      chk({tag, "_y_data"}, out_y_data, 0);
   endtask

   initial begin
      int n;
      fl[0] = 32'h3F80_0000; fl[1] = 32'h4000_0000; fl[2] = 32'h4040_0000;
      fl[3] = 32'h4080_0000; fl[4] = 32'h40A0_0000; fl[5] = 32'h40C0_0000;
      //         len  v    x    y   flt budget done
      vecs[0] = '{3,   100, 100, 100, 1, 200,  1};
      vecs[1] = '{1,   100, 100, 100, 0, 100,  1};
      vecs[2] = '{16,  100, 100, 30,  0, 800,  1};
      vecs[3] = '{20,  40,  100, 100, 0, 800,  1};
      vecs[4] = '{100, 70,  60,  50,  0, 5000, 1};

      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      @(negedge clk);
      #1;
      check_reset("por");

      for (int k = 0; k < 5; k++) begin
         load(vecs[k].len, vecs[k].flt, k);
         v_pct = vecs[k].v_pct;
         x_pct = vecs[k].x_pct;
         y_pct = vecs[k].y_pct;
         start_job(vecs[k].len);
         wait_done(vecs[k].budget);
         check_job(vecs[k].len, vecs[k].exp_done);
      end

      // x port stalled: x FIFO fills after FIFO_DEPTH words and input stalls in phase X
      load(8, 0, 5);
      v_pct = 100; x_pct = 0; y_pct = 100;
      start_job(8);
      repeat (20) @(posedge clk);
      @(negedge clk);
      #1;
      chk("bp_in_ready", 32'(in_ready), 0);
      chk("bp_x_valid", 32'(out_x_valid), 1);
      chk("bp_x_got", got_x.size(), 0);
      chk("bp_y_got", got_y.size(), FIFO_DEPTH);
      chk("bp_accepted", acc_cnt, 2 * FIFO_DEPTH);
      x_pct = 100;
      wait_done(300);
      check_job(8, 1);

      // zero-length job
      load(0, 0, 6);
      start_job(0);
      repeat (5) @(posedge clk);
      @(negedge clk);
      #1;
      chk("zero_done_count", done_cnt, 1);
      chk("zero_busy", 32'(busy), 0);
      chk("zero_in_ready", 32'(in_ready), 0);

      // second start during a running job is ignored
      load(5, 0, 7);
      v_pct = 100; x_pct = 100; y_pct = 100;
      start_job(2);
      @(posedge clk);
      #1;
      cfg_len   = LEN_W'(5);
      cfg_start = 1'b1;
      @(posedge clk);
      #1;
      cfg_start = 1'b0;
      wait_done(100);
      check_job(2, 1);
      repeat (20) @(posedge clk);
      @(negedge clk);
      #1;
      chk("swb_done_count", done_cnt, 1);
      chk("swb_busy", 32'(busy), 0);
      chk("swb_x_got", got_x.size(), 2);
      chk("swb_src_left", src.size(), 6);

      // reset in the middle of a job with words held in both FIFOs
      load(4, 0, 8);
      v_pct = 100; x_pct = 0; y_pct = 0;
      start_job(4);
      n = 0;
      while (acc_cnt < 3 && n < 50) begin
         @(posedge clk);
         n++;
      end
      chk("mr_accepted3", 32'(acc_cnt >= 3), 1);
      @(posedge clk);
      #1 rst_n = 1'b0;
      @(posedge clk);
      #1 rst_n = 1'b1;
      @(negedge clk);
      #1;
      check_reset("midreset");
      x_pct = 100; y_pct = 100;
      load(1, 0, 9);
      start_job(1);
      wait_done(100);
      check_job(1, 1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1, "timeout");
   end
endmodule

// File: doc/fl_vadd_feeder.md
# fl_vadd_feeder

Transmit-side companion to the floating-point vector adder. Accepts a single interleaved AXI-stream of 32-bit words (x0, y0, x1, y1, …) and drives the adder's two operand streams, vector_x and vector_y, through independent small FIFOs so either operand port can stall without blocking the other. A programmed vector length bounds each job. Completion is signalled once every accepted operand has been handed to the adder.

## Interface
Parameters:
- DATA_W, 32, operand word width (IEEE-754 single).
- FIFO_DEPTH, 4, entries per operand FIFO; power of two, ≥2.
- LEN_W, 16, width of the vector-length (pair count) register.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst_n  in  1  synchronous, active-low reset.
- cfg_len  in  LEN_W  number of (x, y) pairs in the job; sampled on cfg_start.
- cfg_start  in  1  one-cycle job start pulse.
- busy  out  1  high from accepted start until done.
- done  out  1  one-cycle completion pulse.
- in_data  in  DATA_W  interleaved operand word.
- in_valid  in  1  in_data valid.
- in_ready  out  1  feeder can accept in_data.
- out_x_data  out  DATA_W  x operand to adder vector_x.
- out_x_valid  out  1  x operand valid.
- x_ready  in  1  adder accepts x.
- out_x_last  out  1  final x of job (see Configuration).
- out_y_data  out  DATA_W  y operand to adder vector_y.
- out_y_valid  out  1  y operand valid.
- y_ready  in  1  adder accepts y.
- out_y_last  out  1  final y of job (see Configuration).

## Operation
- States: IDLE, RUN, DRAIN.
- IDLE: in_ready=0. cfg_start with cfg_len≠0 → latch length, clear pair counter, phase=X, go RUN, busy=1. cfg_start with cfg_len=0 → done pulses next cycle, stays IDLE, busy stays 0.
- RUN: phase X → in_ready = !x_full; handshake pushes in_data into x FIFO, phase→Y. Phase Y → in_ready = !y_full; handshake pushes into y FIFO, phase→X, pair counter +1. When pair counter reaches latched length on a Y push → DRAIN, in_ready=0 from next cycle.
- DRAIN: no input accepted. When both FIFOs empty → done=1 for one cycle, busy=0, go IDLE.
- cfg_start outside IDLE is ignored; latched length unchanged.
- Output side: out_*_valid = FIFO not empty; pop on valid&&ready. Data/valid remain stable while stalled (AXI-stream rules).
- Pair counter is LEN_W bits; max job 2^LEN_W−1 pairs; no wrap within a job.
- Reset (any state, including mid-job): FIFOs flushed, state IDLE, phase X, counter 0; in-flight words discarded.

## Timing
- Reset values: in_ready=0, busy=0, done=0, out_x_valid=0, out_y_valid=0, out_x_last=0, out_y_last=0, out data 0.
- busy rises the cycle after cfg_start.
- Latency: a word accepted at edge t is presented on its output port after edge t (1 cycle min).
- in_ready is combinational from phase and FIFO fullness; no full-FIFO pass-through (push blocked when full, even if popping same cycle).
- Simultaneous push and pop on a non-full FIFO: both occur, occupancy unchanged.
- Peak throughput: 1 input word/cycle; each operand stream receives one word every 2 cycles.
- done asserts the cycle after the last pop of the later FIFO to empty.

## Configuration
- FL_VADD_FEEDER_TLAST_EN defined: each FIFO carries a last bit; out_x_last/out_y_last assert with the job's final x/y entry (pair index = length−1) and follow valid/ready like data.
- Undefined: no last bit stored; out_x_last and out_y_last tied 0. All other behaviour identical.

## Test plan
- Basic: cfg_len=3, stream 1.0,2.0,3.0,4.0,5.0,6.0 with ready high → x sees 1.0,3.0,5.0, y sees 2.0,4.0,6.0; done one cycle after last pop; with TLAST_EN, last only on 5.0/6.0.
- Backpressure: cfg_len=8, x_ready=0, y_ready=1 → after 4 x words (FIFO_DEPTH) in_ready stays 0 in phase X; release x_ready → all 8 pairs delivered in order, no loss/duplication.
- Zero length: cfg_start with cfg_len=0 → done pulse next cycle, busy never 1, in_ready stays 0.
- Start while busy: second cfg_start (cfg_len=5) during job of length 2 → ignored; exactly 2 pairs transferred, one done.
- Mid-job reset: rst_n low for one cycle after 3 words accepted → all outputs at reset values next cycle; new job of cfg_len=1 starts with phase X and completes correctly.
- Random: random valid/ready on all three streams, cfg_len=100 → output streams match scoreboard exactly, single done.
